// File: rtl/rggen_axi4lite_bridge_timeout.sv
// rggen bus -> AXI4-Lite master bridge with registered outputs and an optional
// response timeout; late responses after a timeout are drained silently.
module rggen_axi4lite_bridge_timeout #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH      = 32,
  parameter logic [2:0]  PROT           = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  // rggen bus side
  input  logic                     i_bus_valid,
  input  logic                     i_bus_write,
  input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
  input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
  output logic                     o_bus_ready,
  output logic [1:0]               o_bus_status,
  output logic [BUS_WIDTH-1:0]     o_bus_read_data,
  // AXI4-Lite write address / data / response
  output logic                     o_awvalid,
  input  logic                     i_awready,
  output logic [ADDRESS_WIDTH-1:0] o_awaddr,
  output logic [2:0]               o_awprot,
  output logic                     o_wvalid,
  input  logic                     i_wready,
  output logic [BUS_WIDTH-1:0]     o_wdata,
  output logic [BUS_WIDTH/8-1:0]   o_wstrb,
  input  logic                     i_bvalid,
  output logic                     o_bready,
  input  logic [1:0]               i_bresp,
  // AXI4-Lite read address / data
  output logic                     o_arvalid,
  input  logic                     i_arready,
  output logic [ADDRESS_WIDTH-1:0] o_araddr,
  output logic [2:0]               o_arprot,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [BUS_WIDTH-1:0]     i_rdata,
  input  logic [1:0]               i_rresp
);

  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] REQUEST  = 3'd1;
  localparam logic [2:0] RESPONSE = 3'd2;
  localparam logic [2:0] DONE     = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;

  // rggen status shares the AXI resp encoding, so responses map by direct cast
  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;

  logic [2:0]               r_state;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [BUS_WIDTH-1:0]     r_wdata;
  logic [STRB_WIDTH-1:0]    r_strobe;
  logic                     r_aw_done;
  logic                     r_w_done;
  logic                     r_awvalid;
  logic                     r_wvalid;
  logic                     r_arvalid;
  logic                     r_bready;
  logic                     r_rready;
  logic                     r_ready;
  logic [1:0]               r_status;
  logic [BUS_WIDTH-1:0]     r_read_data;
  logic                     r_pending;

  logic [2:0]               w_state_next;
  logic                     w_write_next;
  logic [ADDRESS_WIDTH-1:0] w_address_next;
  logic [BUS_WIDTH-1:0]     w_wdata_next;
  logic [STRB_WIDTH-1:0]    w_strobe_next;
  logic                     w_aw_done_next;
  logic                     w_w_done_next;
  logic                     w_awvalid_next;
  logic                     w_wvalid_next;
  logic                     w_arvalid_next;
  logic                     w_bready_next;
  logic                     w_rready_next;
  logic                     w_ready_next;
  logic [1:0]               w_status_next;
  logic [BUS_WIDTH-1:0]     w_read_data_next;
  logic                     w_pending_next;

  logic                     w_resp;
  logic                     w_expire;

  assign w_resp = r_write ? (i_bvalid & r_bready) : (i_rvalid & r_rready);

  // Response timeout counter; absent entirely when the timeout is disabled
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      logic [CNT_WIDTH-1:0] r_count;
      logic [CNT_WIDTH-1:0] w_count_next;

      always_comb begin
        w_count_next = r_count;
        if (r_state != RESPONSE) begin
          w_count_next = '0;
        end else if (!w_resp && (r_count != CNT_WIDTH'(TIMEOUT_CYCLES))) begin
          w_count_next = r_count + CNT_WIDTH'(1);
        end
      end

      // expiry is the cycle in which the count would reach the limit
      assign w_expire = (r_state == RESPONSE) && !w_resp &&
                        (r_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_count <= '0;
        end else begin
          r_count <= w_count_next;
        end
      end
    end else begin : g_no_timeout
      assign w_expire = 1'b0;
    end
  endgenerate

  // Next-state and next-output decode
  always_comb begin
    w_state_next     = r_state;
    w_write_next     = r_write;
    w_address_next   = r_address;
    w_wdata_next     = r_wdata;
    w_strobe_next    = r_strobe;
    w_aw_done_next   = r_aw_done;
    w_w_done_next    = r_w_done;
    w_awvalid_next   = r_awvalid;
    w_wvalid_next    = r_wvalid;
    w_arvalid_next   = r_arvalid;
    w_bready_next    = r_bready;
    w_rready_next    = r_rready;
    w_ready_next     = 1'b0;
    w_status_next    = r_status;
    w_read_data_next = r_read_data;
    w_pending_next   = r_pending;

    case (r_state)
      IDLE: begin
        if (i_bus_valid) begin
          w_write_next   = i_bus_write;
          w_address_next = i_bus_address;
          w_wdata_next   = i_bus_write_data;
          w_strobe_next  = i_bus_strobe;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
          w_awvalid_next = i_bus_write;
          w_wvalid_next  = i_bus_write;
          w_arvalid_next = !i_bus_write;
          w_state_next   = REQUEST;
        end
      end
      REQUEST: begin
        if (r_write) begin
          w_aw_done_next = r_aw_done | (r_awvalid & i_awready);
          w_w_done_next  = r_w_done  | (r_wvalid  & i_wready);
          w_awvalid_next = !w_aw_done_next;
          w_wvalid_next  = !w_w_done_next;
          if (w_aw_done_next && w_w_done_next) begin
            w_bready_next = 1'b1;
            w_state_next  = RESPONSE;
          end
        end else if (r_arvalid && i_arready) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
          w_state_next   = RESPONSE;
        end
      end
      RESPONSE: begin
        if (w_resp) begin
          w_status_next    = r_write ? i_bresp : i_rresp;
          w_read_data_next = r_write ? '0 : i_rdata;
          w_bready_next    = 1'b0;
          w_rready_next    = 1'b0;
          w_ready_next     = 1'b1;
          w_state_next     = DONE;
        end else if (w_expire) begin
          w_status_next    = RGGEN_SLAVE_ERROR;
          w_read_data_next = '0;
          w_pending_next   = 1'b1;
          w_bready_next    = 1'b0;
          w_rready_next    = 1'b0;
          w_ready_next     = 1'b1;
          w_state_next     = DONE;
        end
      end
      DONE: begin
        // a timed-out slave still owes a response; reopen the channel for it
        w_bready_next  = r_pending & r_write;
        w_rready_next  = r_pending & !r_write;
        w_pending_next = 1'b0;
        w_state_next   = r_pending ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (w_resp) begin
          w_bready_next = 1'b0;
          w_rready_next = 1'b0;
          w_state_next  = IDLE;
        end
      end
      default: begin
        w_awvalid_next = 1'b0;
        w_wvalid_next  = 1'b0;
        w_arvalid_next = 1'b0;
        w_bready_next  = 1'b0;
        w_rready_next  = 1'b0;
        w_pending_next = 1'b0;
        w_state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_strobe    <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_ready     <= 1'b0;
      r_status    <= RGGEN_OKAY;
      r_read_data <= '0;
      r_pending   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_write     <= w_write_next;
      r_address   <= w_address_next;
      r_wdata     <= w_wdata_next;
      r_strobe    <= w_strobe_next;
      r_aw_done   <= w_aw_done_next;
      r_w_done    <= w_w_done_next;
      r_awvalid   <= w_awvalid_next;
      r_wvalid    <= w_wvalid_next;
      r_arvalid   <= w_arvalid_next;
      r_bready    <= w_bready_next;
      r_rready    <= w_rready_next;
      r_ready     <= w_ready_next;
      r_status    <= w_status_next;
      r_read_data <= w_read_data_next;
      r_pending   <= w_pending_next;
    end
  end

  assign o_bus_ready     = r_ready;
  assign o_bus_status    = r_status;
  assign o_bus_read_data = r_read_data;
  assign o_awvalid       = r_awvalid;
  assign o_awaddr        = r_address;
  assign o_awprot        = PROT;
  assign o_wvalid        = r_wvalid;
  assign o_wdata         = r_wdata;
  assign o_wstrb         = r_strobe;
  assign o_bready        = r_bready;
  assign o_arvalid       = r_arvalid;
  assign o_araddr        = r_address;
  assign o_arprot        = PROT;
  assign o_rready        = r_rready;

endmodule
